regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: wb0 (ALU) and wb1 (load unit).
- Uses round-robin arbitration with a valid/ready handshake and a registered write stage that drives the register file wr_ena/wr_addr/wr_data.
- Keeps a 32-entry pending-write scoreboard so issue logic can stall on registers with outstanding writes.

Parameters:
FIRST_PRIO, 0, requester (0 or 1) that wins the first tie after reset

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous active-high reset
wb0_valid  input  1  requester 0 has a write
wb0_ready  output  1  requester 0 write accepted this cycle
wb0_addr  input  5  requester 0 destination register
wb0_data  input  32  requester 0 write data
wb1_valid  input  1  requester 1 has a write
wb1_ready  output  1  requester 1 write accepted this cycle
wb1_addr  input  5  requester 1 destination register
wb1_data  input  32  requester 1 write data
rsv_ena  input  1  reserve destination at issue
rsv_addr  input  5  register being reserved
chk_addr0  input  5  scoreboard query address 0
chk_addr1  input  5  scoreboard query address 1
chk_busy0  output  1  chk_addr0 has a pending write
chk_busy1  output  1  chk_addr1 has a pending write
wr_ena  output  1  register file write enable
wr_addr  output  5  register file write address
wr_data  output  32  register file write data

Behaviour:
- Reset values: wr_ena=0, wr_addr=0, wr_data=0, busy vector all 0, last_grant=!FIRST_PRIO. wb0_ready and wb1_ready are forced to 0 while rst=1.
- Grant is combinational from valids and last_grant:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - Neither valid: no grant.
- wbK_ready = grant==K. Ready never depends on a requester's own valid beyond the grant. The write stage always accepts, so there is no backpressure other than losing arbitration.
- Handshake (valid & ready) at edge E:
  - last_grant <= winner.
  - wr_addr <= addr, wr_data <= data.
  - wr_ena <= (addr != 0).
- No handshake at E: wr_ena <= 0. wr_addr and wr_data hold their values.
- Latency:
  - The register file captures the write at E+1.
  - Read data reflects the write from the cycle after E+1.
  - Throughput is one write per cycle.
- x0 handling: an addr=0 write completes its handshake but never asserts wr_ena. x0 is never reserved.
- Scoreboard: busy[31:0], with busy[0] constant 0.
  - Set: at an edge with rsv_ena=1, rst=0 and rsv_addr!=0, busy[rsv_addr] <= 1.
  - Clear: at an edge where wr_ena=1 (the same edge the register file writes), busy[wr_addr] <= 0.
  - Set and clear of the same address at the same edge: set wins (newer writer outstanding).
  - A clear of an unreserved register is harmless.
- chk_busyK = busy[chk_addrK], combinational. It is 0 for address 0.
- Reset mid-operation:
  - A write already on wr_* with wr_ena=1 at the reset edge still lands in the register file, which has no reset.
  - All scoreboard state is cleared.
  - rsv_ena is ignored while rst=1.
  - No new handshakes occur while rst=1.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- When defined:
  - Adds outputs fwd_hit0/fwd_hit1 (1 bit) and fwd_data0/fwd_data1 (32 bits).
  - fwd_hitK = wr_ena & (wr_addr == chk_addrK) & (chk_addrK != 0), and fwd_dataK = wr_data.
  - chk_busyK is deasserted when fwd_hitK=1, unless a same-cycle rsv_ena targets that address.
- When undefined: these ports do not exist, and chk_busy stays high until the clearing edge.

Test Plan:
- Single requester: wb0 valid, addr=5, data=0xDEADBEEF. Required: wb0_ready=1 the same cycle; next cycle wr_ena=1, wr_addr=5, wr_data=0xDEADBEEF; the cycle after, wr_ena=0.
- Contention: both valid for 4 cycles after reset (FIRST_PRIO=0), wb0 addr=1..4, wb1 addr=11..14. Required: grants alternate 0,1,0,1, and the wr_addr sequence is 1,11,2,12.
- x0 drop: wb1 writes addr=0, data=0x1234. Required: wb1_ready=1, wr_ena stays 0, chk_busy for addr 0 stays 0.
- Scoreboard: rsv_ena addr=7, then 3 cycles later a wb0 write to addr=7. Required: chk_busy0 (chk_addr0=7) is high from the cycle after rsv through the cycle wr_ena=1, and low afterward. A same-edge rsv of 7 during that clear leaves busy=1.
- Reset mid-stream: rst asserted while wr_ena=1 (addr=9) and busy[9]=1 and busy[3]=1. Required: the next cycle has wr_ena=0, all chk_busy=0, and both ready=0 during reset.
- REGFILE_WB_FWD_EN: chk_addr1=9 while wr_ena=1, wr_addr=9, wr_data=0xA5A5A5A5. Required: fwd_hit1=1, fwd_data1=0xA5A5A5A5, chk_busy1=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback,
// with a 32-entry pending-write scoreboard. Define REGFILE_WB_FWD_EN for write-stage forwarding.
module regfile_wb_arbiter #(
  parameter int unsigned FIRST_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb0_valid,
  output logic        wb0_ready,
  input  logic [4:0]  wb0_addr,
  input  logic [31:0] wb0_data,
  input  logic        wb1_valid,
  output logic        wb1_ready,
  input  logic [4:0]  wb1_addr,
  input  logic [31:0] wb1_data,
  input  logic        rsv_ena,
  input  logic [4:0]  rsv_addr,
  input  logic [4:0]  chk_addr0,
  input  logic [4:0]  chk_addr1,
  output logic        chk_busy0,
  output logic        chk_busy1,
`ifdef REGFILE_WB_FWD_EN
  output logic        fwd_hit0,
  output logic        fwd_hit1,
  output logic [31:0] fwd_data0,
  output logic [31:0] fwd_data1,
`endif
  output logic        wr_ena,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data
);

  logic        last_grant_q;
  logic        gnt0, gnt1;
  logic        wr_ena_q;
  logic [4:0]  wr_addr_q;
  logic [31:0] wr_data_q;
  logic [31:0] busy_q, busy_d;

  // last_grant_q holds the previous winner; a tie goes to the other requester.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (wb0_valid && wb1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = wb0_valid;
        gnt1 = wb1_valid;
      end
    end
  end

  assign wb0_ready = gnt0;
  assign wb1_ready = gnt1;

  // Reservation applied after the clear so a newer writer stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (wr_ena_q) busy_d[wr_addr_q] = 1'b0;
    if (rsv_ena) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= (FIRST_PRIO == 0) ? 1'b1 : 1'b0;
      wr_ena_q     <= 1'b0;
      wr_addr_q    <= 5'd0;
      wr_data_q    <= 32'd0;
      busy_q       <= 32'd0;
    end else begin
      wr_ena_q <= 1'b0;
      if (gnt0) begin
        last_grant_q <= 1'b0;
        wr_addr_q    <= wb0_addr;
        wr_data_q    <= wb0_data;
        wr_ena_q     <= (wb0_addr != 5'd0);
      end else if (gnt1) begin
        last_grant_q <= 1'b1;
        wr_addr_q    <= wb1_addr;
        wr_data_q    <= wb1_data;
        wr_ena_q     <= (wb1_addr != 5'd0);
      end
      busy_q <= busy_d;
    end
  end

  assign wr_ena  = wr_ena_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef REGFILE_WB_FWD_EN
  logic rsv_hit0, rsv_hit1;

  always_comb begin
    fwd_hit0  = wr_ena_q && (wr_addr_q == chk_addr0) && (chk_addr0 != 5'd0);
    fwd_hit1  = wr_ena_q && (wr_addr_q == chk_addr1) && (chk_addr1 != 5'd0);
    fwd_data0 = wr_data_q;
    fwd_data1 = wr_data_q;
    rsv_hit0  = rsv_ena && !rst && (rsv_addr == chk_addr0);
    rsv_hit1  = rsv_ena && !rst && (rsv_addr == chk_addr1);
    // A forwarded value satisfies the reader unless a newer writer is being reserved.
    chk_busy0 = busy_q[chk_addr0] && !(fwd_hit0 && !rsv_hit0);
    chk_busy1 = busy_q[chk_addr1] && !(fwd_hit1 && !rsv_hit1);
  end
`else
  assign chk_busy0 = busy_q[chk_addr0];
  assign chk_busy1 = busy_q[chk_addr1];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vectors plus a per-cycle reference model.
module tb_regfile_wb_arbiter;

  localparam int FIRST_PRIO = 0;

  logic        clk;
  logic        rst;
  logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [4:0]  wb0_addr, wb1_addr, rsv_addr, chk_addr0, chk_addr1, wr_addr;
  logic [31:0] wb0_data, wb1_data, wr_data;
  logic        rsv_ena, chk_busy0, chk_busy1, wr_ena;
`ifdef REGFILE_WB_FWD_EN
  logic        fwd_hit0, fwd_hit1;
  logic [31:0] fwd_data0, fwd_data1;
`endif

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.FIRST_PRIO(FIRST_PRIO)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb0_valid (wb0_valid),
    .wb0_ready (wb0_ready),
    .wb0_addr  (wb0_addr),
    .wb0_data  (wb0_data),
    .wb1_valid (wb1_valid),
    .wb1_ready (wb1_ready),
    .wb1_addr  (wb1_addr),
    .wb1_data  (wb1_data),
    .rsv_ena   (rsv_ena),
    .rsv_addr  (rsv_addr),
    .chk_addr0 (chk_addr0),
    .chk_addr1 (chk_addr1),
    .chk_busy0 (chk_busy0),
    .chk_busy1 (chk_busy1),
`ifdef REGFILE_WB_FWD_EN
    .fwd_hit0  (fwd_hit0),
    .fwd_hit1  (fwd_hit1),
    .fwd_data0 (fwd_data0),
    .fwd_data1 (fwd_data1),
`endif
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state as it stands after the most recent rising edge.
  bit [31:0]   pend;
  bit          mvalid = 1'b0;
  int          mlast;
  bit          m_ena;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  always @(negedge clk) begin : model
    int win;
    bit exp_b0, exp_b1;
    win = -1;
    if (!rst) begin
      if (wb0_valid && wb1_valid) win = 1 - mlast;
      else if (wb0_valid) win = 0;
      else if (wb1_valid) win = 1;
    end
    exp_b0 = pend[chk_addr0];
    exp_b1 = pend[chk_addr1];
`ifdef REGFILE_WB_FWD_EN
    begin
      bit h0, h1;
      h0 = m_ena && (m_addr == chk_addr0) && (chk_addr0 != 0);
      h1 = m_ena && (m_addr == chk_addr1) && (chk_addr1 != 0);
      if (h0 && !(rsv_ena && !rst && rsv_addr == chk_addr0)) exp_b0 = 1'b0;
      if (h1 && !(rsv_ena && !rst && rsv_addr == chk_addr1)) exp_b1 = 1'b0;
      if (mvalid) begin
        check1("m_fwd_hit0", fwd_hit0, h0);
        check1("m_fwd_hit1", fwd_hit1, h1);
        check32("m_fwd_data0", fwd_data0, m_data);
        check32("m_fwd_data1", fwd_data1, m_data);
      end
    end
`endif
    if (mvalid) begin
      check1("m_wb0_ready", wb0_ready, win == 0);
      check1("m_wb1_ready", wb1_ready, win == 1);
      check1("m_wr_ena", wr_ena, m_ena);
      check32("m_wr_addr", 32'(wr_addr), 32'(m_addr));
      check32("m_wr_data", wr_data, m_data);
      check1("m_chk_busy0", chk_busy0, exp_b0);
      check1("m_chk_busy1", chk_busy1, exp_b1);
    end
    if (rst) begin
      mvalid = 1'b1;
      pend   = '0;
      mlast  = 1 - FIRST_PRIO;
      m_ena  = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else if (mvalid) begin
      if (m_ena) pend[m_addr] = 1'b0;
      if (rsv_ena && rsv_addr != 0) pend[rsv_addr] = 1'b1;
      m_ena = 1'b0;
      if (win == 0) begin
        mlast = 0; m_addr = wb0_addr; m_data = wb0_data; m_ena = (wb0_addr != 0);
      end else if (win == 1) begin
        mlast = 1; m_addr = wb1_addr; m_data = wb1_data; m_ena = (wb1_addr != 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    rsv_ena   = 1'b0;
  endtask

  logic [4:0] lit_addr [4];
  logic       lit_gnt1 [4];
  logic [4:0] a0, a1;

  initial begin
    lit_addr = '{5'd1, 5'd11, 5'd2, 5'd12};
    lit_gnt1 = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    rsv_ena = 1'b0; rsv_addr = '0; chk_addr0 = '0; chk_addr1 = '0;
    a0 = 5'd1; a1 = 5'd11;
    wb0_valid = 1'b1; wb0_addr = a0; wb0_data = 32'h100 + 32'(a0);
    wb1_valid = 1'b1; wb1_addr = a1; wb1_data = 32'h200 + 32'(a1);

    // Reset holds both readies low even with valids asserted.
    @(negedge clk);
    check1("rst_ready0", wb0_ready, 1'b0);
    check1("rst_ready1", wb1_ready, 1'b0);
    step();
    @(negedge clk);
    check1("rst_wr_ena", wr_ena, 1'b0);
    check32("rst_wr_addr", 32'(wr_addr), 32'd0);
    check32("rst_wr_data", wr_data, 32'd0);
    step();
    rst = 1'b0;

    // Contention: grants alternate starting with wb0.
    for (int k = 0; k < 4; k++) begin
      wb0_addr = a0; wb0_data = 32'h100 + 32'(a0);
      wb1_addr = a1; wb1_data = 32'h200 + 32'(a1);
      @(negedge clk);
      check1("cont_ready0", wb0_ready, !lit_gnt1[k]);
      check1("cont_ready1", wb1_ready, lit_gnt1[k]);
      if (k > 0) check32("cont_wr_addr", 32'(wr_addr), 32'(lit_addr[k-1]));
      if (wb0_ready) a0 = a0 + 5'd1;
      if (wb1_ready) a1 = a1 + 5'd1;
      step();
    end
    idle();
    @(negedge clk);
    check32("cont_wr_addr_last", 32'(wr_addr), 32'd12);
    check32("cont_wr_data_last", wr_data, 32'h20c);
    step();

    // Single requester.
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    @(negedge clk);
    check1("single_ready0", wb0_ready, 1'b1);
    step();
    idle();
    @(negedge clk);
    check1("single_wr_ena", wr_ena, 1'b1);
    check32("single_wr_addr", 32'(wr_addr), 32'd5);
    check32("single_wr_data", wr_data, 32'hDEADBEEF);
    step();
    @(negedge clk);
    check1("single_wr_ena_off", wr_ena, 1'b0);
    check32("single_addr_hold", 32'(wr_addr), 32'd5);
    step();

    // x0 write completes the handshake but never enables the write.
    wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = 32'h1234;
    @(negedge clk);
    check1("x0_ready1", wb1_ready, 1'b1);
    step();
    idle();
    @(negedge clk);
    check1("x0_wr_ena", wr_ena, 1'b0);
    check32("x0_wr_data", wr_data, 32'h1234);
    check1("x0_busy", chk_busy0, 1'b0);
    step();

    // Scoreboard set, hold, clear.
    chk_addr0 = 5'd7; rsv_ena = 1'b1; rsv_addr = 5'd7;
    @(negedge clk);
    check1("sb_before", chk_busy0, 1'b0);
    step();
    rsv_ena = 1'b0;
    @(negedge clk);
    check1("sb_set", chk_busy0, 1'b1);
    step();
    step();
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h77;
    @(negedge clk);
    check1("sb_hold", chk_busy0, 1'b1);
    step();
    idle();
    @(negedge clk);
    check1("sb_wr_ena", wr_ena, 1'b1);
`ifdef REGFILE_WB_FWD_EN
    check1("sb_clear_edge", chk_busy0, 1'b0);
`else
    check1("sb_clear_edge", chk_busy0, 1'b1);
`endif
    step();
    @(negedge clk);
    check1("sb_cleared", chk_busy0, 1'b0);
    step();

    // Same-edge reserve and clear: reserve wins.
    rsv_ena = 1'b1; rsv_addr = 5'd7;
    step();
    rsv_ena = 1'b0; wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h78;
    step();
    wb0_valid = 1'b0; rsv_ena = 1'b1; rsv_addr = 5'd7;
    @(negedge clk);
    check1("same_wr_ena", wr_ena, 1'b1);
    check1("same_busy_during", chk_busy0, 1'b1);
    step();
    rsv_ena = 1'b0;
    @(negedge clk);
    check1("same_busy_after", chk_busy0, 1'b1);
    step();
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h79;
    step();
    idle();
    step();
    @(negedge clk);
    check1("same_final_clear", chk_busy0, 1'b0);
    step();

    // Reset mid-stream with a write on the port and two reservations.
    chk_addr0 = 5'd9; chk_addr1 = 5'd3; rsv_ena = 1'b1; rsv_addr = 5'd9;
    step();
    rsv_addr = 5'd3;
    step();
    rsv_ena = 1'b0; wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h99;
    step();
    wb0_valid = 1'b1; wb0_addr = 5'd4; wb1_valid = 1'b1; wb1_addr = 5'd6;
    rst = 1'b1; rsv_ena = 1'b1; rsv_addr = 5'd3;
    @(negedge clk);
    check1("mid_ready0", wb0_ready, 1'b0);
    check1("mid_ready1", wb1_ready, 1'b0);
    check1("mid_wr_ena", wr_ena, 1'b1);
    check32("mid_wr_addr", 32'(wr_addr), 32'd9);
    check1("mid_busy3", chk_busy1, 1'b1);
    step();
    @(negedge clk);
    check1("mid_after_wr_ena", wr_ena, 1'b0);
    check1("mid_after_busy0", chk_busy0, 1'b0);
    check1("mid_after_busy1", chk_busy1, 1'b0);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check1("mid_rsv_ignored", chk_busy1, 1'b0);
    step();

`ifdef REGFILE_WB_FWD_EN
    chk_addr1 = 5'd9; rsv_ena = 1'b1; rsv_addr = 5'd9;
    step();
    rsv_ena = 1'b0; wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'hA5A5A5A5;
    step();
    idle();
    @(negedge clk);
    check1("fwd_hit1", fwd_hit1, 1'b1);
    check32("fwd_data1", fwd_data1, 32'hA5A5A5A5);
    check1("fwd_busy1", chk_busy1, 1'b0);
    step();
`endif

    step();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
